code_pulse_generator: RTL and testbench

- Downstream of the signal transceiver sequencer. Consumes its GEN/CODE/CODE_LEN/CODE_DURATION/PULSE_LEN outputs and returns SIGNAL_GEN_OVER.
- Produces the BPSK phase bit and the RF transmit gate for one coded pulse, which feed the AD9911 phase/amplitude control pins.
- Runs one pulse per GEN assertion, then holds completion until the sequencer drops GEN.

---
 rtl/code_pulse_generator.sv | 261 ++++++++++++++++++++++++++
 tb/tb_code_pulse_generator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_pulse_generator.sv
// -----------------------------------------------------------------------------
// code_pulse_generator
//
// Generates one BPSK-coded RF pulse per rising edge of GEN. The chip pattern
// drives PHASE (0 = 0 deg, 1 = 180 deg) and TX_GATE opens the RF path while
// chips are being sent. After the chips, the block keeps BUSY high until the
// minimum pulse window has elapsed, then raises SIGNAL_GEN_OVER and holds it
// until the sequencer drops GEN.
//
// Ports
//   CLOCK_10M        in   system clock (10 MHz)
//   RESET            in   asynchronous, active-high reset
//   GEN              in   level request from the sequencer
//   CODE[31:0]       in   chip pattern, bit 0 transmitted first
//   CODE_LEN[15:0]   in   number of chips (clamped to MAX_CHIPS)
//   CODE_DURATION    in   clocks per chip (0 treated as 1)
//   PULSE_LEN[15:0]  in   minimum pulse window in clocks
//   SIGNAL_GEN_OVER  out  pulse complete, held until GEN is low
//   SIGNAL_GEN_BUSY  out  high for the whole pulse window
//   TX_GATE          out  RF gate, high while chips are transmitted
//   PHASE            out  current chip bit, PHASE_IDLE when the gate is closed
//
// MAX_CHIPS must lie in 1..32 because CODE is 32 bits wide.
// -----------------------------------------------------------------------------
module code_pulse_generator #(
    parameter int   MAX_CHIPS  = 32,
    parameter logic PHASE_IDLE = 1'b0
) (
    input  logic        CLOCK_10M,
    input  logic        RESET,
    input  logic        GEN,
    input  logic [31:0] CODE,
    input  logic [15:0] CODE_LEN,
    input  logic [15:0] CODE_DURATION,
    input  logic [15:0] PULSE_LEN,
    output logic        SIGNAL_GEN_OVER,
    output logic        SIGNAL_GEN_BUSY,
    output logic        TX_GATE,
    output logic        PHASE
);

    // Chip index has to reach MAX_CHIPS itself (one past the last chip).
    localparam int IDX_W = $clog2(MAX_CHIPS + 1);
    // Window counter wide enough for MAX_CHIPS * 65535 without overflow
    // (21 bits for 32 chips).
    localparam int WIN_W = $clog2(MAX_CHIPS * 65535 + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHIP,
        ST_GAP,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic                gen_prev_q, gen_prev_d;
    logic                armed_q,    armed_d;
    logic [IDX_W-1:0]    len_q,      len_d;
    logic [15:0]         dur_q,      dur_d;
    logic [31:0]         code_q,     code_d;
    logic [WIN_W-1:0]    win_q,      win_d;
    logic [IDX_W-1:0]    chip_idx_q, chip_idx_d;
    logic [15:0]         chip_cnt_q, chip_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q,  win_cnt_d;
    logic                tx_q,       tx_d;
    logic                phase_q,    phase_d;
    logic                busy_q,     busy_d;
    logic                over_q,     over_d;

    // ------------------------------------------------------------------
    // Operands captured on the start edge, derived straight from the inputs
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]    len_in;
    logic [15:0]         dur_in;
    logic [WIN_W-1:0]    prod_in;
    logic [WIN_W-1:0]    win_in;
    logic                start;
    logic [IDX_W-1:0]    chip_idx_inc;
    logic [4:0]          code_sel;

    always_comb begin
        len_in = (CODE_LEN > 16'(MAX_CHIPS)) ? IDX_W'(MAX_CHIPS)
                                             : CODE_LEN[IDX_W-1:0];
        dur_in = (CODE_DURATION == 16'd0) ? 16'd1 : CODE_DURATION;

        // Window = max(PULSE_LEN, len*dur, 1). The product only reaches zero
        // when there are no chips, since dur is forced to at least 1.
        prod_in = WIN_W'(len_in) * WIN_W'(dur_in);
        win_in  = prod_in;
        if (WIN_W'(PULSE_LEN) > win_in) begin
            win_in = WIN_W'(PULSE_LEN);
        end
        if (win_in == '0) begin
            win_in = WIN_W'(1);
        end
    end

    // A start needs a genuine rising edge of GEN. armed_q stays low after
    // reset until GEN has been seen low once, so a GEN that is already high
    // when reset releases never looks like a fresh request.
    assign start = GEN & ~gen_prev_q & armed_q & (state_q == ST_IDLE);

    assign chip_idx_inc = chip_idx_q + IDX_W'(1);
    assign code_sel     = 5'(chip_idx_inc);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gen_prev_d = GEN;
        armed_d    = armed_q | ~GEN;
        len_d      = len_q;
        dur_d      = dur_q;
        code_d     = code_q;
        win_d      = win_q;
        chip_idx_d = chip_idx_q;
        chip_cnt_d = chip_cnt_q;
        win_cnt_d  = win_cnt_q;
        tx_d       = tx_q;
        phase_d    = phase_q;
        busy_d     = busy_q;
        over_d     = over_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = len_in;
                    dur_d     = dur_in;
                    code_d    = CODE;
                    win_d     = win_in;
                    busy_d    = 1'b1;
                    win_cnt_d = WIN_W'(1);
                    if (len_in != '0) begin
                        state_d    = ST_CHIP;
                        tx_d       = 1'b1;
                        phase_d    = CODE[0];
                        chip_idx_d = '0;
                        chip_cnt_d = 16'd1;
                    end else begin
                        // No chips: only the window runs, gate stays closed.
                        state_d = ST_GAP;
                    end
                end
            end

            ST_CHIP: begin
                if (!GEN) begin
                    // Sequencer withdrew the request: close the gate at once,
                    // no completion indication.
                    state_d = ST_IDLE;
                    tx_d    = 1'b0;
                    phase_d = PHASE_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    if (chip_cnt_q == dur_q) begin
                        chip_cnt_d = 16'd1;
                        chip_idx_d = chip_idx_inc;
                        if (chip_idx_inc < len_q) begin
                            phase_d = code_q[code_sel];
                        end else begin
                            tx_d    = 1'b0;
                            phase_d = PHASE_IDLE;
                            // When the chips exactly fill the window, skip the
                            // gap so BUSY lasts exactly win cycles.
                            if (win_cnt_q == win_q) begin
                                state_d = ST_DONE;
                                busy_d  = 1'b0;
                                over_d  = 1'b1;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end
                    end else begin
                        chip_cnt_d = chip_cnt_q + 16'd1;
                    end
                end
            end

            ST_GAP: begin
                if (!GEN) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b0;
                    phase_d = PHASE_IDLE;
                    busy_d  = 1'b0;
                end else if (win_cnt_q == win_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    over_d  = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end

            ST_DONE: begin
                // Release on the edge after GEN was first sampled low, so OVER
                // drops two edges after the sequencer lets go of GEN. A GEN
                // rise seen here is ignored; only IDLE accepts a start.
                if (!gen_prev_q) begin
                    state_d = ST_IDLE;
                    over_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b0;
                phase_d = PHASE_IDLE;
                busy_d  = 1'b0;
                over_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            gen_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            len_q      <= '0;
            dur_q      <= '0;
            code_q     <= '0;
            win_q      <= '0;
            chip_idx_q <= '0;
            chip_cnt_q <= '0;
            win_cnt_q  <= '0;
            tx_q       <= 1'b0;
            phase_q    <= PHASE_IDLE;
            busy_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_prev_q <= gen_prev_d;
            armed_q    <= armed_d;
            len_q      <= len_d;
            dur_q      <= dur_d;
            code_q     <= code_d;
            win_q      <= win_d;
            chip_idx_q <= chip_idx_d;
            chip_cnt_q <= chip_cnt_d;
            win_cnt_q  <= win_cnt_d;
            tx_q       <= tx_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            over_q     <= over_d;
        end
    end

    assign SIGNAL_GEN_OVER = over_q;
    assign SIGNAL_GEN_BUSY = busy_q;
    assign TX_GATE         = tx_q;
    assign PHASE           = phase_q;

endmodule

// File: tb/tb_code_pulse_generator.sv
`timescale 1ns/1ps
// Testbench for code_pulse_generator. Stimulus pushes the expected shape of
// each pulse into a queue; a monitor measures every BUSY window the DUT
// produces and compares it against the head of the queue.
module tb_code_pulse_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen;
    logic [31:0] code;
    logic [15:0] code_len;
    logic [15:0] code_dur;
    logic [15:0] pulse_len;
    logic        over;
    logic        busy;
    logic        tx;
    logic        phase;

    always #50 clk = ~clk;

    code_pulse_generator #(
        .MAX_CHIPS  (32),
        .PHASE_IDLE (1'b0)
    ) dut (
        .CLOCK_10M       (clk),
        .RESET           (rst),
        .GEN             (gen),
        .CODE            (code),
        .CODE_LEN        (code_len),
        .CODE_DURATION   (code_dur),
        .PULSE_LEN       (pulse_len),
        .SIGNAL_GEN_OVER (over),
        .SIGNAL_GEN_BUSY (busy),
        .TX_GATE         (tx),
        .PHASE           (phase)
    );

    typedef struct {
        string       name;
        int          busy_cyc;
        int          tx_cyc;
        int          tx_first;
        logic [63:0] bits;
        bit          over;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input string nm, input logic [31:0] c, input logic [15:0] l,
                               input logic [15:0] d, input logic [15:0] p, input bit push,
                               input int eb, input int et, input int ef,
                               input logic [63:0] ebits, input bit eo);
        exp_t e;
        if (push) begin
            e.name     = nm;
            e.busy_cyc = eb;
            e.tx_cyc   = et;
            e.tx_first = ef;
            e.bits     = ebits;
            e.over     = eo;
            exp_q.push_back(e);
        end
        code      = c;
        code_len  = l;
        code_dur  = d;
        pulse_len = p;
        gen       = 1'b1;
    endtask

    task automatic wait_over(input string nm, input int budget);
        int n;
        n = 0;
        while (over !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (over !== 1'b1) begin
            errors++;
            $display("FAIL %s.over_timeout: got over=%b expected 1 within %0d cycles", nm, over, budget);
        end
    endtask

    // Sequencer handshake: drop GEN after OVER is seen, keep it low 2 cycles.
    task automatic finish_pulse();
        tick(1);
        gen = 1'b0;
        tick(2);
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures each BUSY window, one line per completed pulse
    // ------------------------------------------------------------------
    initial begin
        bit          in_win;
        int          b_cyc, t_cyc, t_first, runs;
        logic [63:0] bits;
        bit          prev_tx, idle_ok;
        exp_t        e;
        in_win = 1'b0;
        b_cyc = 0; t_cyc = 0; t_first = -1; runs = 0;
        bits = '0; prev_tx = 1'b0; idle_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_win = 1'b0;
            end else begin
                if (!in_win && busy) begin
                    in_win  = 1'b1;
                    b_cyc   = 0;
                    t_cyc   = 0;
                    t_first = -1;
                    runs    = 0;
                    bits    = '0;
                    prev_tx = 1'b0;
                    idle_ok = 1'b1;
                end
                if (in_win) begin
                    if (busy) begin
                        b_cyc++;
                        if (tx) begin
                            if (t_first < 0) t_first = b_cyc - 1;
                            if (!prev_tx) runs++;
                            if (t_cyc < 64) bits[t_cyc] = phase;
                            t_cyc++;
                        end else if (phase !== 1'b0) begin
                            idle_ok = 1'b0;
                        end
                        prev_tx = tx;
                    end else begin
                        in_win = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pulse: got busy window of %0d cycles expected none", b_cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk({e.name, ".busy_cycles"}, 64'(b_cyc), 64'(e.busy_cyc));
                            chk({e.name, ".tx_cycles"}, 64'(t_cyc), 64'(e.tx_cyc));
                            chk({e.name, ".tx_first"}, 64'(t_first), 64'(e.tx_first));
                            chk({e.name, ".phase_bits"}, bits, e.bits);
                            chk({e.name, ".tx_runs"}, 64'(runs), (e.tx_cyc > 0) ? 64'd1 : 64'd0);
                            chk({e.name, ".phase_idle"}, 64'(idle_ok), 64'd1);
                            chk({e.name, ".over"}, 64'(over), 64'(e.over));
                            chk({e.name, ".tx_end"}, 64'(tx), 64'd0);
                            $display("pulse %s: busy=%0d tx=%0d first=%0d bits=%0h over=%b",
                                     e.name, b_cyc, t_cyc, t_first, bits, over);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; gen = 1'b0;
        code = '0; code_len = '0; code_dur = '0; pulse_len = '0;
        repeat (2) @(negedge clk);
        chk("reset.over",  64'(over),  64'd0);
        chk("reset.busy",  64'(busy),  64'd0);
        chk("reset.tx",    64'(tx),    64'd0);
        chk("reset.phase", 64'(phase), 64'd0);
        #20 rst = 1'b0;
        tick(3);

        // Pulse 1: 0xD, 4 chips x 3 clocks, 20-clock window.
        // PHASE per cycle 1,1,1,0,0,0,1,1,1,1,1,1 -> bits 0xFC7.
        start_pulse("t1", 32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b1, 20, 12, 0, 64'hFC7, 1'b1);
        @(negedge clk);
        chk("t1.latency_pre", 64'(tx), 64'd0);
        tick(1);
        // Inputs changed after the start edge must not disturb the pulse.
        code = 32'h0; code_len = 16'd1; code_dur = 16'd7; pulse_len = 16'd2;
        @(negedge clk);
        chk("t1.latency_tx", 64'(tx), 64'd1);
        chk("t1.first_chip", 64'(phase), 64'd1);
        wait_over("t1", 40);
        tick(5);
        @(negedge clk);
        chk("t1.no_retrigger", 64'(busy), 64'd0);
        chk("t1.over_held", 64'(over), 64'd1);
        tick(1);
        gen = 1'b0;
        tick(1);
        @(negedge clk);
        chk("t1.over_edge1", 64'(over), 64'd1);
        tick(1);
        @(negedge clk);
        chk("t1.over_edge2", 64'(over), 64'd0);
        tick(2);

        // Pulse 2: 40 chips clamped to 32, 1 clock each, window = 32.
        start_pulse("t2", 32'hA5C3_0F96, 16'd40, 16'd1, 16'd0, 1'b1, 32, 32, 0, 64'hA5C3_0F96, 1'b1);
        wait_over("t2", 60);
        finish_pulse();

        // Pulse 3: no chips, window of 5.
        start_pulse("t3", 32'hFFFF_FFFF, 16'd0, 16'd0, 16'd5, 1'b1, 5, 0, -1, 64'h0, 1'b1);
        wait_over("t3", 20);
        finish_pulse();

        // Abort during the 4th cycle of the 12-cycle chip train.
        start_pulse("abort", 32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b1, 4, 4, 0, 64'h7, 1'b0);
        tick(4);
        gen = 1'b0;
        tick(1);
        @(negedge clk);
        chk("abort.tx", 64'(tx), 64'd0);
        chk("abort.busy", 64'(busy), 64'd0);
        tick(10);
        @(negedge clk);
        chk("abort.no_over", 64'(over), 64'd0);
        tick(1);
        start_pulse("after_abort", 32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b1, 20, 12, 0, 64'hFC7, 1'b1);
        wait_over("after_abort", 40);
        finish_pulse();

        // Back-to-back with the 2-cycle GEN-low handshake.
        start_pulse("b2b_a", 32'h0000_0005, 16'd3, 16'd2, 16'd0, 1'b1, 6, 6, 0, 64'h33, 1'b1);
        @(negedge clk);
        chk("b2b_a.over_low", 64'(over), 64'd0);
        wait_over("b2b_a", 20);
        finish_pulse();
        start_pulse("b2b_b", 32'h0000_0002, 16'd2, 16'd1, 16'd4, 1'b1, 4, 2, 0, 64'h2, 1'b1);
        @(negedge clk);
        chk("b2b_b.over_low", 64'(over), 64'd0);
        wait_over("b2b_b", 20);
        finish_pulse();
        start_pulse("b2b_c", 32'hFFFF_FFFE, 16'd5, 16'd1, 16'd5, 1'b1, 5, 5, 0, 64'h1E, 1'b1);
        @(negedge clk);
        chk("b2b_c.over_low", 64'(over), 64'd0);
        wait_over("b2b_c", 20);
        finish_pulse();

        // Reset in the middle of a chip; GEN stays high across it.
        start_pulse("rst_run", 32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b0, 0, 0, 0, 64'h0, 1'b0);
        tick(5);
        #10;
        chk("rst.pre_tx", 64'(tx), 64'd1);
        #10 rst = 1'b1;
        #5;
        chk("rst.tx", 64'(tx), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.over", 64'(over), 64'd0);
        chk("rst.phase", 64'(phase), 64'd0);
        tick(2);
        #20 rst = 1'b0;
        tick(5);
        @(negedge clk);
        chk("rst.stay_idle_busy", 64'(busy), 64'd0);
        chk("rst.stay_idle_tx", 64'(tx), 64'd0);
        tick(1);
        gen = 1'b0;
        tick(2);
        start_pulse("after_rst", 32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b1, 20, 12, 0, 64'hFC7, 1'b1);
        wait_over("after_rst", 40);
        finish_pulse();

        tick(5);
        chk("scoreboard.pending", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
